// File: rtl/reaction_pkg.sv
// Shared types and helpers for the reaction-game round controller.
// States, winner encodings and the LFSR step function live here.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GO     = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    // Right-shifting Galois form of x^11 + x^9 + 1.
    localparam logic [10:0] LFSR_TAPS = 11'h500;

    function automatic logic [10:0] lfsr_next(input logic [10:0] cur);
        logic [10:0] nxt;
        nxt = {1'b0, cur[10:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    // A hit before go hands the round to the other player; a double hit voids it.
    function automatic logic [1:0] false_start_winner(input logic p1, input logic p2);
        logic [1:0] w;
        if (p1 && p2) begin
            w = W_NONE;
        end else if (p1) begin
            w = W_P2;
        end else begin
            w = W_P1;
        end
        return w;
    endfunction

    function automatic logic [1:0] go_winner(input logic p1, input logic p2);
        logic [1:0] w;
        if (p1 && p2) begin
            w = W_TIE;
        end else if (p1) begin
            w = W_P1;
        end else begin
            w = W_P2;
        end
        return w;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
// clr restarts the count so the caller can align intervals to its own state changes.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic cin,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round initiator for the two-player reaction game: random pre-go delay, go light,
// reaction timing in ms, false-start and timeout detection, valid/ack result hand-off.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter logic [10:0] RAND_MASK    = 11'h3FF,
    parameter int unsigned TIMEOUT_MS   = 5000,
    parameter logic [10:0] LFSR_SEED    = 11'h5A5
) (
    input  logic        cin,
    input  logic        rst,
    input  logic        start,
    input  logic        p1_hit,
    input  logic        p2_hit,
    input  logic        result_ack,
    output logic        busy,
    output logic        go_led,
    output logic        result_valid,
    output logic [1:0]  winner,
    output logic        false_start,
    output logic [15:0] react_ms
);

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_MS);
    localparam logic [15:0] MIN_DELAY   = 16'(MIN_DELAY_MS);

    state_e      state_q, state_d;
    logic [10:0] lfsr_q, lfsr_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  winner_q, winner_d;
    logic        false_start_q, false_start_d;
    logic [15:0] react_ms_q, react_ms_d;

    logic tick;
    logic tick_clr;
    logic any_hit;
    logic delay_done;
    logic timeout_now;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .cin  (cin),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    assign lfsr_d  = lfsr_next(lfsr_q);
    assign any_hit = p1_hit | p2_hit;

    // GO is entered on the tick that takes the delay to zero, not one cycle later.
    assign delay_done  = (delay_q == 16'd0) || (tick && (delay_q == 16'd1));
    assign timeout_now = (count_q >= TIMEOUT_VAL) ||
                         (tick && (count_q == TIMEOUT_VAL - 16'd1));

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        count_d       = count_q;
        winner_d      = winner_q;
        false_start_d = false_start_q;
        react_ms_d    = react_ms_q;
        tick_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    delay_d  = MIN_DELAY + {5'b0, lfsr_q & RAND_MASK};
                    tick_clr = 1'b1;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (any_hit) begin
                    winner_d      = false_start_winner(p1_hit, p2_hit);
                    false_start_d = 1'b1;
                    react_ms_d    = 16'd0;
                    state_d       = REPORT;
                end else if (delay_done) begin
                    delay_d  = 16'd0;
                    count_d  = 16'd0;
                    tick_clr = 1'b1;
                    state_d  = GO;
                end else if (tick) begin
                    delay_d = delay_q - 16'd1;
                end
            end

            GO: begin
                if (any_hit) begin
                    winner_d      = go_winner(p1_hit, p2_hit);
                    false_start_d = 1'b0;
                    react_ms_d    = count_q;
                    state_d       = REPORT;
                end else if (timeout_now) begin
                    winner_d      = W_NONE;
                    false_start_d = 1'b0;
                    react_ms_d    = TIMEOUT_VAL;
                    count_d       = TIMEOUT_VAL;
                    state_d       = REPORT;
                end else if (tick) begin
                    count_d = count_q + 16'd1;
                end
            end

            REPORT: begin
                if (result_ack) begin
                    winner_d      = W_NONE;
                    false_start_d = 1'b0;
                    react_ms_d    = 16'd0;
                    count_d       = 16'd0;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            delay_q       <= 16'd0;
            count_q       <= 16'd0;
            winner_q      <= W_NONE;
            false_start_q <= 1'b0;
            react_ms_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            delay_q       <= delay_d;
            count_q       <= count_d;
            winner_q      <= winner_d;
            false_start_q <= false_start_d;
            react_ms_q    <= react_ms_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign go_led       = (state_q == GO);
    assign result_valid = (state_q == REPORT);
    assign winner       = winner_q;
    assign false_start  = false_start_q;
    assign react_ms     = react_ms_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with a 4-cycle ms tick, 3 ms fixed delay and 10 ms timeout.
// Cycle 0 of each round is the cycle start is driven; go is expected in cycle 13.
module tb_reaction_round_ctrl;

    logic        cin;
    logic        rst;
    logic        start;
    logic        p1_hit;
    logic        p2_hit;
    logic        result_ack;
    logic        busy;
    logic        go_led;
    logic        result_valid;
    logic [1:0]  winner;
    logic        false_start;
    logic [15:0] react_ms;

    int checks = 0;
    int errors = 0;

    reaction_round_ctrl #(
        .TICK_DIV     (4),
        .MIN_DELAY_MS (3),
        .RAND_MASK    (11'h000),
        .TIMEOUT_MS   (10),
        .LFSR_SEED    (11'h5A5)
    ) dut (
        .cin          (cin),
        .rst          (rst),
        .start        (start),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .result_ack   (result_ack),
        .busy         (busy),
        .go_led       (go_led),
        .result_valid (result_valid),
        .winner       (winner),
        .false_start  (false_start),
        .react_ms     (react_ms)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    task automatic adv(input int n);
        repeat (n) @(negedge cin);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic g, input logic v,
                           input logic [1:0] w, input logic fs, input logic [15:0] r);
        chk({tag, "/busy"}, 32'(busy), 32'(b));
        chk({tag, "/go_led"}, 32'(go_led), 32'(g));
        chk({tag, "/result_valid"}, 32'(result_valid), 32'(v));
        chk({tag, "/winner"}, 32'(winner), 32'(w));
        chk({tag, "/false_start"}, 32'(false_start), 32'(fs));
        chk({tag, "/react_ms"}, 32'(react_ms), 32'(r));
    endtask

    // Drives start in cycle 0; returns at cycle 1.
    task automatic start_round();
        start = 1'b1;
        adv(1);
        start = 1'b0;
    endtask

    task automatic ack_round(input string tag);
        result_ack = 1'b1;
        adv(1);
        result_ack = 1'b0;
        chk_all(tag, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        p1_hit     = 1'b0;
        p2_hit     = 1'b0;
        result_ack = 1'b0;
        adv(3);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
        rst = 1'b0;
        adv(1);

        // Hits in IDLE do nothing.
        p1_hit = 1'b1;
        p2_hit = 1'b1;
        adv(1);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        chk_all("idle_hits", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);

        // Round 1: p1 wins 9 cycles after go.
        start_round();
        chk("r1_busy_c1", 32'(busy), 32'd1);
        chk("r1_go_c1", 32'(go_led), 32'd0);
        adv(11);
        chk("r1_go_c12", 32'(go_led), 32'd0);
        adv(1);
        chk("r1_go_c13", 32'(go_led), 32'd1);
        adv(9);
        p1_hit = 1'b1;
        chk("r1_valid_c22", 32'(result_valid), 32'd0);
        adv(1);
        p1_hit = 1'b0;
        chk_all("r1_result", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 16'd2);

        // Result held while ack stays low; stray start/hits are ignored.
        for (int i = 0; i < 20; i++) begin
            start  = (i == 3);
            p2_hit = (i == 7) || (i == 11);
            p1_hit = (i == 11) || (i == 15);
            adv(1);
            chk_all("r1_hold", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 16'd2);
        end
        start  = 1'b0;
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        ack_round("r1_ack");

        // Round 2: p2 false start in WAIT.
        start_round();
        adv(4);
        p2_hit = 1'b1;
        adv(1);
        p2_hit = 1'b0;
        chk_all("r2_false_p2", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 16'd0);
        for (int i = 0; i < 12; i++) begin
            adv(1);
            chk("r2_go_never", 32'(go_led), 32'd0);
        end
        ack_round("r2_ack");

        // Round 3: no hit, timeout 40 cycles after go.
        start_round();
        adv(12);
        chk("r3_go_c13", 32'(go_led), 32'd1);
        adv(39);
        chk("r3_valid_c52", 32'(result_valid), 32'd0);
        chk("r3_go_c52", 32'(go_led), 32'd1);
        adv(1);
        chk_all("r3_timeout", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 16'd10);
        ack_round("r3_ack");

        // Round 4: simultaneous hits in GO -> tie.
        start_round();
        adv(13);
        p1_hit = 1'b1;
        p2_hit = 1'b1;
        adv(1);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        chk_all("r4_tie", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 16'd0);
        ack_round("r4_ack");

        // Round 5: simultaneous hits in the delay-expiry cycle -> false start, no winner.
        start_round();
        adv(11);
        chk("r5_go_c12", 32'(go_led), 32'd0);
        p1_hit = 1'b1;
        p2_hit = 1'b1;
        adv(1);
        p1_hit = 1'b0;
        p2_hit = 1'b0;
        chk_all("r5_false_both", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 16'd0);
        ack_round("r5_ack");

        // Round 6: p2 hit in the timeout cycle beats the timeout.
        start_round();
        adv(51);
        p2_hit = 1'b1;
        adv(1);
        p2_hit = 1'b0;
        chk_all("r6_hit_at_timeout", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 16'd9);
        ack_round("r6_ack");

        // Round 7: reset mid-GO, then a clean round.
        start_round();
        adv(14);
        chk("r7_go_c15", 32'(go_led), 32'd1);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk_all("r7_reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0);
        start_round();
        adv(11);
        chk("r7b_go_c12", 32'(go_led), 32'd0);
        adv(1);
        chk("r7b_go_c13", 32'(go_led), 32'd1);
        p1_hit = 1'b1;
        adv(1);
        p1_hit = 1'b0;
        chk_all("r7b_result", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 16'd0);
        ack_round("r7b_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
